// File: rtl/ips_bram_tdp_if.sv
// Port-side signal bundle for the true-dual-port BRAM model.
// The master drives both access ports; the slave returns read data and valid strobes.
interface ips_bram_tdp_if #(
   parameter int WD_BRAM_ADR = 8,
   parameter int WD_BRAM_DAT = 32
) ();
   localparam int NB_BYTE = WD_BRAM_DAT / 8;

   logic                   ena;
   logic [NB_BYTE-1:0]     wea;
   logic [WD_BRAM_ADR-1:0] addra;
   logic [WD_BRAM_DAT-1:0] dina;
   logic [WD_BRAM_DAT-1:0] douta;
   logic                   vlda;

   logic                   enb;
   logic [NB_BYTE-1:0]     web;
   logic [WD_BRAM_ADR-1:0] addrb;
   logic [WD_BRAM_DAT-1:0] dinb;
   logic [WD_BRAM_DAT-1:0] doutb;
   logic                   vldb;

   modport master (
      output ena, wea, addra, dina, enb, web, addrb, dinb,
      input  douta, vlda, doutb, vldb
   );

   modport slave (
      input  ena, wea, addra, dina, enb, web, addrb, dinb,
      output douta, vlda, doutb, vldb
   );
endinterface

// File: rtl/ips_bram_tdp.sv
// Single-clock true-dual-port simulation BRAM with byte enables, selectable
// read-during-write mode, per-port read-valid pipelines and collision arbitration.
module ips_bram_tdp #(
   parameter int NB_BRAM_DLY = 2,
   parameter int WD_BRAM_ADR = 8,
   parameter int WD_BRAM_DAT = 32,
   parameter int MD_BRAM_RDW = 0
) (
   input  logic          i_sys_clk,
   input  logic          i_sys_resetn,
   ips_bram_tdp_if.slave s_bram_0,
   output logic          o_bram_coll,
   output logic [15:0]   o_bram_coll_cnt
);
   localparam int NB_BYTE  = WD_BRAM_DAT / 8;
   localparam int NB_DEPTH = 2 ** WD_BRAM_ADR;

   typedef enum logic [1:0] {
      RDW_WRITE_FIRST = 2'd0,
      RDW_READ_FIRST  = 2'd1,
      RDW_NO_CHANGE   = 2'd2
   } rdw_mode_t;

   localparam logic [1:0] RDW_BITS = MD_BRAM_RDW[1:0];
   localparam rdw_mode_t  RDW_MODE = rdw_mode_t'(RDW_BITS);

   logic [WD_BRAM_DAT-1:0] mem [NB_DEPTH];

   logic                   wr_a, wr_b, coll;
   logic [WD_BRAM_DAT-1:0] old_a, old_b, fin_a, fin_b;
   logic [WD_BRAM_DAT-1:0] ld_a, ld_b;
   logic                   ld_en_a, ld_en_b;

   logic [WD_BRAM_DAT-1:0] dout_a_q [NB_BRAM_DLY];
   logic [WD_BRAM_DAT-1:0] dout_b_q [NB_BRAM_DLY];
   logic [NB_BRAM_DLY-1:0] vld_a_q, vld_b_q;

   // On a collision both final words describe the same location: A owns its
   // enabled lanes, B fills the lanes A left alone.
   always_comb begin
      wr_a  = s_bram_0.ena && (|s_bram_0.wea);
      wr_b  = s_bram_0.enb && (|s_bram_0.web);
      coll  = s_bram_0.ena && s_bram_0.enb &&
              (s_bram_0.addra == s_bram_0.addrb) && (wr_a || wr_b);
      old_a = mem[s_bram_0.addra];
      old_b = mem[s_bram_0.addrb];
      fin_a = old_a;
      fin_b = old_b;
      for (int k = 0; k < NB_BYTE; k++) begin
         if (s_bram_0.wea[k])
            fin_a[8*k +: 8] = s_bram_0.dina[8*k +: 8];
         else if (coll && s_bram_0.web[k])
            fin_a[8*k +: 8] = s_bram_0.dinb[8*k +: 8];
         if (coll && s_bram_0.wea[k])
            fin_b[8*k +: 8] = s_bram_0.dina[8*k +: 8];
         else if (s_bram_0.web[k])
            fin_b[8*k +: 8] = s_bram_0.dinb[8*k +: 8];
      end
   end

   // A pure read always sees the pre-edge word, which is also what a
   // cross-port read of a colliding write must return.
   always_comb begin
      ld_en_a = 1'b0;
      ld_a    = old_a;
      ld_en_b = 1'b0;
      ld_b    = old_b;
      if (s_bram_0.ena) begin
         if (!wr_a || RDW_MODE == RDW_READ_FIRST) begin
            ld_en_a = 1'b1;
         end else if (RDW_MODE == RDW_WRITE_FIRST) begin
            ld_en_a = 1'b1;
            ld_a    = fin_a;
         end
      end
      if (s_bram_0.enb) begin
         if (!wr_b || RDW_MODE == RDW_READ_FIRST) begin
            ld_en_b = 1'b1;
         end else if (RDW_MODE == RDW_WRITE_FIRST) begin
            ld_en_b = 1'b1;
            ld_b    = fin_b;
         end
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_resetn) begin
         for (int i = 0; i < NB_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_b) mem[s_bram_0.addrb] <= fin_b;
         if (wr_a) mem[s_bram_0.addra] <= fin_a;
      end
   end

   // Stage 0 holds when nothing loads it, so dout keeps the last read result.
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_resetn) begin
         for (int i = 0; i < NB_BRAM_DLY; i++) begin
            dout_a_q[i] <= '0;
            dout_b_q[i] <= '0;
         end
         vld_a_q <= '0;
         vld_b_q <= '0;
      end else begin
         if (ld_en_a) dout_a_q[0] <= ld_a;
         if (ld_en_b) dout_b_q[0] <= ld_b;
         vld_a_q[0] <= ld_en_a;
         vld_b_q[0] <= ld_en_b;
         for (int i = 1; i < NB_BRAM_DLY; i++) begin
            dout_a_q[i] <= dout_a_q[i-1];
            dout_b_q[i] <= dout_b_q[i-1];
            vld_a_q[i]  <= vld_a_q[i-1];
            vld_b_q[i]  <= vld_b_q[i-1];
         end
      end
   end

   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_resetn) begin
         o_bram_coll     <= 1'b0;
         o_bram_coll_cnt <= '0;
      end else begin
         o_bram_coll <= coll;
         if (coll && o_bram_coll_cnt != 16'hFFFF)
            o_bram_coll_cnt <= o_bram_coll_cnt + 16'd1;
      end
   end

   assign s_bram_0.douta = dout_a_q[NB_BRAM_DLY-1];
   assign s_bram_0.vlda  = vld_a_q[NB_BRAM_DLY-1];
   assign s_bram_0.doutb = dout_b_q[NB_BRAM_DLY-1];
   assign s_bram_0.vldb  = vld_b_q[NB_BRAM_DLY-1];
endmodule

// File: tb/tb_ips_bram_tdp.sv
// Bench for ips_bram_tdp: three instances (WRITE_FIRST/DLY2, READ_FIRST/DLY3,
// NO_CHANGE/DLY1) share one stimulus stream and are checked against a word-level memory model.
module tb_ips_bram_tdp;
   logic        sys_clk = 1'b0;
   logic        sys_resetn = 1'b0;
   logic        ena = 1'b0, enb = 1'b0;
   logic [3:0]  wea = '0, web = '0;
   logic [7:0]  addra = '0, addrb = '0;
   logic [31:0] dina = '0, dinb = '0;

   logic [2:0][31:0] obs_douta, obs_doutb;
   logic [2:0]       obs_vlda, obs_vldb, obs_coll;
   logic [2:0][15:0] obs_cnt;

   always #5 sys_clk = ~sys_clk;

   // Instance g uses read-during-write mode g; latencies are 2, 3 and 1.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      ips_bram_tdp_if #(.WD_BRAM_ADR(8), .WD_BRAM_DAT(32)) bus ();
      assign bus.ena   = ena;
      assign bus.wea   = wea;
      assign bus.addra = addra;
      assign bus.dina  = dina;
      assign bus.enb   = enb;
      assign bus.web   = web;
      assign bus.addrb = addrb;
      assign bus.dinb  = dinb;
      assign obs_douta[g] = bus.douta;
      assign obs_vlda[g]  = bus.vlda;
      assign obs_doutb[g] = bus.doutb;
      assign obs_vldb[g]  = bus.vldb;

      ips_bram_tdp #(
         .NB_BRAM_DLY (g == 0 ? 2 : (g == 1 ? 3 : 1)),
         .WD_BRAM_ADR (8),
         .WD_BRAM_DAT (32),
         .MD_BRAM_RDW (g)
      ) u_dut (
         .i_sys_clk       (sys_clk),
         .i_sys_resetn    (sys_resetn),
         .s_bram_0        (bus),
         .o_bram_coll     (obs_coll[g]),
         .o_bram_coll_cnt (obs_cnt[g])
      );
   end

   // Reference model: the memory contents plus, per instance and port, a short
   // history of what each edge launched (valid flag, word last loaded into the read path).
   logic [31:0] mem_m [256];
   logic [31:0] ldd_a [3][16];
   logic [31:0] ldd_b [3][16];
   logic        lv_a  [3][16];
   logic        lv_b  [3][16];
   int          last_rst [3];
   int          cyc = 0;
   logic        coll_exp = 1'b0;
   int          cnt_exp = 0;
   int          checks = 0;
   int          errors = 0;

   function automatic int dlyOf(input int c);
      return (c == 0) ? 2 : ((c == 1) ? 3 : 1);
   endfunction

   function automatic logic [31:0] pat(input logic [7:0] a);
      return {a, ~a, a ^ 8'h3C, a + 8'h11};
   endfunction

   task automatic check32(input string name, input int c, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s cfg%0d cycle %0d observed=%h expected=%h", name, c, cyc, obs, expv);
      end
   endtask

   task automatic launch(input int c, input int idx, input int prv, input bit port_b,
                         input logic en, input logic wr, input logic [31:0] oldw, input logic [31:0] finw);
      logic        ld, v;
      logic [31:0] d;
      ld = 1'b0; v = 1'b0; d = oldw;
      if (en && !wr) begin
         ld = 1'b1; v = 1'b1;
      end else if (en && c == 0) begin
         ld = 1'b1; v = 1'b1; d = finw;
      end else if (en && c == 1) begin
         ld = 1'b1; v = 1'b1;
      end
      if (port_b) begin
         ldd_b[c][idx] = ld ? d : ldd_b[c][prv];
         lv_b[c][idx]  = v;
      end else begin
         ldd_a[c][idx] = ld ? d : ldd_a[c][prv];
         lv_a[c][idx]  = v;
      end
   endtask

   task automatic modelEdge();
      int idx, prv;
      logic [31:0] old_a, old_b, fin_a, fin_b;
      logic wr_a, wr_b, hit;
      idx = cyc % 16;
      prv = (cyc + 15) % 16;
      if (!sys_resetn) begin
         foreach (mem_m[i]) mem_m[i] = '0;
         for (int c = 0; c < 3; c++) begin
            last_rst[c] = cyc;
            ldd_a[c][idx] = '0; lv_a[c][idx] = 1'b0;
            ldd_b[c][idx] = '0; lv_b[c][idx] = 1'b0;
         end
         coll_exp = 1'b0;
         cnt_exp  = 0;
      end else begin
         old_a = mem_m[addra];
         old_b = mem_m[addrb];
         wr_a  = ena && (wea != 4'h0);
         wr_b  = enb && (web != 4'h0);
         hit   = ena && enb && (addra == addrb) && (wr_a || wr_b);
         // B's bytes land first and A's on top, so A owns any lane both enable.
         for (int k = 0; k < 4; k++) if (wr_b && web[k]) mem_m[addrb][8*k +: 8] = dinb[8*k +: 8];
         for (int k = 0; k < 4; k++) if (wr_a && wea[k]) mem_m[addra][8*k +: 8] = dina[8*k +: 8];
         fin_a = mem_m[addra];
         fin_b = mem_m[addrb];
         for (int c = 0; c < 3; c++) begin
            launch(c, idx, prv, 1'b0, ena, wr_a, old_a, fin_a);
            launch(c, idx, prv, 1'b1, enb, wr_b, old_b, fin_b);
         end
         coll_exp = hit;
         if (hit && cnt_exp < 65535) cnt_exp++;
      end
   endtask

   task automatic checkOutput();
      int k;
      logic [31:0] ea, eb;
      logic va, vb;
      for (int c = 0; c < 3; c++) begin
         k = cyc - dlyOf(c) + 1;
         if (k < 0 || k < last_rst[c]) begin
            ea = '0; eb = '0; va = 1'b0; vb = 1'b0;
         end else begin
            ea = ldd_a[c][k % 16]; va = lv_a[c][k % 16];
            eb = ldd_b[c][k % 16]; vb = lv_b[c][k % 16];
         end
         check32("douta", c, obs_douta[c], ea);
         check32("vlda", c, 32'(obs_vlda[c]), 32'(va));
         check32("doutb", c, obs_doutb[c], eb);
         check32("vldb", c, 32'(obs_vldb[c]), 32'(vb));
         check32("coll", c, 32'(obs_coll[c]), 32'(coll_exp));
         check32("coll_cnt", c, 32'(obs_cnt[c]), cnt_exp);
      end
   endtask

   task automatic applyStimulus(input logic rst_n,
                                input logic en_a, input logic [3:0] we_a, input logic [7:0] ad_a, input logic [31:0] di_a,
                                input logic en_b, input logic [3:0] we_b, input logic [7:0] ad_b, input logic [31:0] di_b);
      sys_resetn = rst_n;
      ena = en_a; wea = we_a; addra = ad_a; dina = di_a;
      enb = en_b; web = we_b; addrb = ad_b; dinb = di_b;
      @(posedge sys_clk);
      cyc++;
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic idleStep();
      applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
   endtask

   task automatic writeA(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
      applyStimulus(1'b1, 1'b1, we, a, d, 1'b0, 4'h0, 8'h0, 32'h0);
   endtask

   task automatic readA(input logic [7:0] a);
      applyStimulus(1'b1, 1'b1, 4'h0, a, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
   endtask

   initial begin
      int run, best;
      logic [7:0] ra, rb;
      foreach (last_rst[c]) last_rst[c] = 0;
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 16; i++) begin
            ldd_a[c][i] = '0; ldd_b[c][i] = '0; lv_a[c][i] = 1'b0; lv_b[c][i] = 1'b0;
         end

      applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);

      // Reset clears a written word; the read shows up one edge later on the DLY2 instance.
      writeA(8'd5, 32'hDEADBEEF, 4'hF);
      applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
      readA(8'd5);
      check32("rst_vlda_early", 0, 32'(obs_vlda[0]), 32'd0);
      idleStep();
      check32("rst_douta", 0, obs_douta[0], 32'h0);
      check32("rst_vlda", 0, 32'(obs_vlda[0]), 32'd1);
      check32("rst_cnt", 0, 32'(obs_cnt[0]), 32'd0);

      // Partial byte-enable overwrite, read back on port B.
      writeA(8'd3, 32'h11223344, 4'hF);
      writeA(8'd3, 32'hAABBCCDD, 4'b0101);
      applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 4'h0, 8'd3, 32'h0);
      idleStep();
      check32("byte_en_doutb", 0, obs_doutb[0], 32'h11BB33DD);

      // Read-during-write on address 7 in all three modes.
      readA(8'd3);
      writeA(8'd7, 32'h1, 4'hF);
      writeA(8'd7, 32'h2, 4'hF);
      check32("nc_douta", 2, obs_douta[2], 32'h11BB33DD);
      check32("nc_vlda", 2, 32'(obs_vlda[2]), 32'd0);
      idleStep();
      check32("wf_douta", 0, obs_douta[0], 32'h2);
      check32("wf_vlda", 0, 32'(obs_vlda[0]), 32'd1);
      idleStep();
      check32("rf_douta", 1, obs_douta[1], 32'h1);
      check32("rf_vlda", 1, 32'(obs_vlda[1]), 32'd1);

      // Dual-write collision with lane arbitration.
      applyStimulus(1'b1, 1'b1, 4'b1100, 8'd9, 32'hAAAA0000, 1'b1, 4'b1111, 8'd9, 32'h0000BBBB);
      check32("coll_pulse", 0, 32'(obs_coll[0]), 32'd1);
      check32("coll_cnt1", 0, 32'(obs_cnt[0]), 32'd1);
      idleStep();
      check32("coll_drop", 0, 32'(obs_coll[0]), 32'd0);
      readA(8'd9);
      idleStep();
      check32("coll_word", 0, obs_douta[0], 32'hAAAABBBB);

      // Read/write collision: B sees the old word, A its own write.
      writeA(8'd9, 32'h5, 4'hF);
      applyStimulus(1'b1, 1'b1, 4'hF, 8'd9, 32'h6, 1'b1, 4'h0, 8'd9, 32'h0);
      check32("rw_coll_pulse", 0, 32'(obs_coll[0]), 32'd1);
      check32("rw_coll_cnt", 0, 32'(obs_cnt[0]), 32'd2);
      idleStep();
      check32("rw_doutb", 0, obs_doutb[0], 32'h5);
      check32("rw_douta", 0, obs_douta[0], 32'h6);

      // Random traffic on a few hot addresses plus the top address, with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         ra = ($urandom_range(0, 4) == 4) ? 8'hFF : 8'($urandom_range(0, 3));
         rb = ($urandom_range(0, 4) == 4) ? 8'hFF : 8'($urandom_range(0, 3));
         applyStimulus(($urandom_range(0, 63) != 0),
                       1'($urandom), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, ra, $urandom,
                       1'($urandom), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, rb, $urandom);
      end

      // Fill the whole array, then stream it out back-to-back on port A.
      for (int a = 0; a < 256; a++) writeA(8'(a), pat(8'(a)), 4'hF);
      for (int i = 0; i < 3; i++) idleStep();
      run = 0; best = 0;
      for (int a = 0; a < 256; a++) begin
         readA(8'(a));
         run = obs_vlda[1] ? run + 1 : 0;
         if (run > best) best = run;
      end
      for (int i = 0; i < 4; i++) begin
         idleStep();
         if (i == 1) check32("stream_last_word", 1, obs_douta[1], pat(8'hFF));
         run = obs_vlda[1] ? run + 1 : 0;
         if (run > best) best = run;
      end
      check32("stream_run", 1, best, 32'd256);

      // Drive the collision counter well past saturation.
      for (int i = 0; i < 70000; i++)
         applyStimulus(1'b1, 1'b1, 4'hF, 8'd0, $urandom, 1'b1, 4'hF, 8'd0, $urandom);
      check32("sat_cnt", 0, 32'(obs_cnt[0]), 32'h0000FFFF);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 4'h0, 8'd0, 32'h0, 1'b1, 4'hF, 8'd0, $urandom);
      for (int c = 0; c < 3; c++) check32("sat_hold", c, 32'(obs_cnt[c]), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
